// File: rtl/p_box_feistel_merge_if.sv
// Handshake and data bundle between the S-box bank and the
// DES P-box merge stage of one Feistel round.
interface p_box_feistel_merge_if;
  logic        Merge_Start;
  logic [32:1] Merge_L_Input;
  logic        S_Box_Select;
  logic [8:1]  S_Box_Finish_Flags;
  logic [32:1] S_Box_Outputs;
  logic [32:1] Merge_Output;
  logic        Merge_Done;
  logic        Merge_Busy;
  logic        Merge_Error;

  modport master (
    output Merge_Start,
    output Merge_L_Input,
    input  S_Box_Select,
    output S_Box_Finish_Flags,
    output S_Box_Outputs,
    input  Merge_Output,
    input  Merge_Done,
    input  Merge_Busy,
    input  Merge_Error
  );

  modport slave (
    input  Merge_Start,
    input  Merge_L_Input,
    output S_Box_Select,
    input  S_Box_Finish_Flags,
    input  S_Box_Outputs,
    output Merge_Output,
    output Merge_Done,
    output Merge_Busy,
    output Merge_Error
  );
endinterface

// File: rtl/p_box_feistel_merge.sv
// DES round merge: strobe the S-boxes, collect their outputs,
// apply P and fold in the left half to form the new right half.
module p_box_feistel_merge #(
  parameter int TIMEOUT_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  p_box_feistel_merge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] TMO = 4'(TIMEOUT_CYCLES);

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // DES bit k lives at index 33-k, so both sides are mirrored
  function automatic logic [32:1] p_perm(
    input logic [32:1] s
  );
    logic [32:1] p;
    p = '0;
    for (int i = 1; i <= 32; i++) begin
      p[33-i] = s[33-P_TAB[i-1]];
    end
    return p;
  endfunction

  state_t      state;
  logic [32:1] l_q;
  logic [3:0]  cnt;
  logic [3:0]  cnt_inc;
  logic        all_done;

  assign cnt_inc  = cnt + 4'd1;
  assign all_done = (bus.S_Box_Finish_Flags == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      l_q              <= '0;
      cnt              <= '0;
      bus.S_Box_Select <= 1'b0;
      bus.Merge_Done   <= 1'b0;
      bus.Merge_Busy   <= 1'b0;
      bus.Merge_Error  <= 1'b0;
      bus.Merge_Output <= '0;
    end else begin
      bus.S_Box_Select <= 1'b0;
      bus.Merge_Done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Merge_Start) begin
            l_q              <= bus.Merge_L_Input;
            bus.Merge_Error  <= 1'b0;
            bus.S_Box_Select <= 1'b1;
            bus.Merge_Busy   <= 1'b1;
            state            <= SELECT;
          end
        end
        SELECT: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // only a complete flag set may sample the S-box bus
          if (all_done) begin
            bus.Merge_Output <= p_perm(bus.S_Box_Outputs) ^ l_q;
            bus.Merge_Done   <= 1'b1;
            state            <= DONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TMO) begin
              bus.Merge_Error <= 1'b1;
              bus.Merge_Busy  <= 1'b0;
              state           <= IDLE;
            end
          end
        end
        DONE: begin
          bus.Merge_Busy <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
